// File: rtl/wb_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_write_arbiter_if
//   Bundles every non-clock/reset signal of the writeback arbiter.
//
//   Parameters : DEPTH (FIFO entries), ADDR_W (register address width),
//                DATA_W (register data width)
//   Signals    :
//     pipe_wen/pipe_waddr/pipe_wdata  in-order pipeline write request
//     lu_valid/lu_ready/lu_waddr/lu_wdata  long-latency result handshake
//     chk_reg/chk_pending             hazard-unit pending-write lookup
//     reg_write/write_reg/write_data  register file write port (registered)
//     fifo_count                      occupied FIFO entries (incl. killed)
//     stall_cnt                       writeback-blocked cycle counter
//   Modports   : master = producer/consumer side, slave = the arbiter
// ---------------------------------------------------------------------------
interface wb_write_arbiter_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              pipe_wen;
  logic [ADDR_W-1:0] pipe_waddr;
  logic [DATA_W-1:0] pipe_wdata;
  logic              lu_valid;
  logic              lu_ready;
  logic [ADDR_W-1:0] lu_waddr;
  logic [DATA_W-1:0] lu_wdata;
  logic [ADDR_W-1:0] chk_reg;
  logic              chk_pending;
  logic              reg_write;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic [CNT_W-1:0]  fifo_count;
  logic [15:0]       stall_cnt;

  modport slave (
    input  pipe_wen, pipe_waddr, pipe_wdata,
    input  lu_valid, lu_waddr, lu_wdata,
    input  chk_reg,
    output lu_ready, chk_pending,
    output reg_write, write_reg, write_data,
    output fifo_count, stall_cnt
  );

  modport master (
    output pipe_wen, pipe_waddr, pipe_wdata,
    output lu_valid, lu_waddr, lu_wdata,
    output chk_reg,
    input  lu_ready, chk_pending,
    input  reg_write, write_reg, write_data,
    input  fifo_count, stall_cnt
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// ---------------------------------------------------------------------------
// wb_write_arbiter
//   Merges the in-order pipeline MEM/WB write (fixed priority) and a buffered
//   long-latency result stream onto the single register file write port.
//   Queued long-latency results that are overwritten by a younger pipeline
//   write to the same register are killed in place (WAW) and later popped
//   without writing. A combinational lookup reports whether a live queued
//   result targets a given register so the hazard unit can stall readers.
//
//   Ports:
//     clk  - clock, all state updates on posedge
//     rst  - asynchronous active-high reset
//     bus  - wb_write_arbiter_if.slave (see interface file for signals)
//
//   Optional feature: define WB_STALL_COUNT_EN to build the saturating
//   counter of cycles where a non-empty FIFO was blocked by a pipeline
//   write; otherwise stall_cnt is tied to zero.
// ---------------------------------------------------------------------------
module wb_write_arbiter #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_write_arbiter_if.slave     bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // FIFO storage and pointers
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  live_q, live_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  // Registered write port
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  // Per-cycle decisions
  logic lu_ready_s;
  logic pipe_fire_s;
  logic pop_s;
  logic push_s;
  logic chk_pending_s;

  // Handshake and arbitration decisions from current state and inputs
  always_comb begin
    // lu_ready deliberately ignores a same-cycle pop: simpler timing, and it
    // guarantees a push never lands in the slot being popped.
    lu_ready_s  = (count_q < CNT_W'(DEPTH));
    pipe_fire_s = bus.pipe_wen && (bus.pipe_waddr != {ADDR_W{1'b0}});
    pop_s       = !pipe_fire_s && (count_q != {CNT_W{1'b0}});
    // Results for r0 complete the handshake but are dropped.
    push_s      = bus.lu_valid && lu_ready_s && (bus.lu_waddr != {ADDR_W{1'b0}});
  end

  // Next-state for FIFO contents, pointers, count and write port
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    live_d       = live_q;
    addr_d       = addr_q;
    data_d       = data_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;

    if (pipe_fire_s) begin
      reg_write_d  = 1'b1;
      write_reg_d  = bus.pipe_waddr;
      write_data_d = bus.pipe_wdata;
      // The pipeline write is younger than anything queued: kill older
      // results to the same register so they cannot overwrite it later.
      for (int i = 0; i < DEPTH; i++) begin
        if (live_q[i] && (addr_q[i] == bus.pipe_waddr)) begin
          live_d[i] = 1'b0;
        end else begin
          live_d[i] = live_q[i];
        end
      end
    end else if (pop_s) begin
      if (live_q[head_q]) begin
        reg_write_d  = 1'b1;
        write_reg_d  = addr_q[head_q];
        write_data_d = data_q[head_q];
      end else begin
        // Killed entry: consume the slot, write nothing, hold addr/data.
        reg_write_d = 1'b0;
      end
      // Clearing live on pop keeps freed slots out of the pending lookup.
      live_d[head_q] = 1'b0;
      head_d         = head_q + PTR_W'(1);
    end else begin
      reg_write_d = 1'b0;
    end

    if (push_s) begin
      live_d[tail_q] = 1'b1;
      addr_d[tail_q] = bus.lu_waddr;
      data_d[tail_q] = bus.lu_wdata;
      tail_d         = tail_q + PTR_W'(1);
    end else begin
      tail_d = tail_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q       <= {PTR_W{1'b0}};
      tail_q       <= {PTR_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      live_q       <= {DEPTH{1'b0}};
      reg_write_q  <= 1'b0;
      write_reg_q  <= {ADDR_W{1'b0}};
      write_data_q <= {DATA_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= {ADDR_W{1'b0}};
        data_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      live_q       <= live_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  // Hazard lookup over stored state only; r0 is never reported pending
  always_comb begin
    chk_pending_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (addr_q[i] == bus.chk_reg) &&
          (bus.chk_reg != {ADDR_W{1'b0}})) begin
        chk_pending_s = 1'b1;
      end else begin
        chk_pending_s = chk_pending_s;
      end
    end
  end

`ifdef WB_STALL_COUNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Count cycles where queued results were held off by a pipeline write
  always_comb begin
    if (pipe_fire_s && (count_q != {CNT_W{1'b0}}) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = 16'h0000;
`endif

  assign bus.lu_ready    = lu_ready_s;
  assign bus.chk_pending = chk_pending_s;
  assign bus.reg_write   = reg_write_q;
  assign bus.write_reg   = write_reg_q;
  assign bus.write_data  = write_data_q;
  assign bus.fifo_count  = count_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_write_arbiter
//   Directed self-checking bench for wb_write_arbiter (DEPTH=4, ADDR_W=5,
//   DATA_W=32). Inputs change 1 time unit after posedge; outputs are sampled
//   at the same point, i.e. after the edge's updates have settled.
// ---------------------------------------------------------------------------
module tb_wb_write_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  wb_write_arbiter_if #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) bus ();

  wb_write_arbiter #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pipe_wen   = 1'b0;
    bus.pipe_waddr = 5'd0;
    bus.pipe_wdata = 32'h0;
    bus.lu_valid   = 1'b0;
    bus.lu_waddr   = 5'd0;
    bus.lu_wdata   = 32'h0;
    bus.chk_reg    = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) step();
    rst = 1'b0;
    step();
    checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write: got %0h exp 0", bus.reg_write); end
    checks++; if (bus.write_reg !== 5'd0) begin errors++; $display("FAIL reset_write_reg: got %0h exp 0", bus.write_reg); end
    checks++; if (bus.write_data !== 32'h0) begin errors++; $display("FAIL reset_write_data: got %0h exp 0", bus.write_data); end
    checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL reset_lu_ready: got %0h exp 1", bus.lu_ready); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_fifo_count: got %0d exp 0", bus.fifo_count); end
    checks++; if (bus.chk_pending !== 1'b0) begin errors++; $display("FAIL reset_chk_pending: got %0h exp 0", bus.chk_pending); end
    checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d exp 0", bus.stall_cnt); end
  endtask

  task automatic test_pipe_write();
    bus.pipe_wen   = 1'b1;
    bus.pipe_waddr = 5'd8;
    bus.pipe_wdata = 32'h1234;
    step();
    checks++; if (bus.reg_write !== 1'b1) begin errors++; $display("FAIL pipe_reg_write: got %0h exp 1", bus.reg_write); end
    checks++; if (bus.write_reg !== 5'd8) begin errors++; $display("FAIL pipe_write_reg: got %0d exp 8", bus.write_reg); end
    checks++; if (bus.write_data !== 32'h1234) begin errors++; $display("FAIL pipe_write_data: got %0h exp 1234", bus.write_data); end
    bus.pipe_wen = 1'b0;
    step();
    checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL pipe_drop_reg_write: got %0h exp 0", bus.reg_write); end
    checks++; if (bus.write_reg !== 5'd8) begin errors++; $display("FAIL pipe_hold_write_reg: got %0d exp 8", bus.write_reg); end
    checks++; if (bus.write_data !== 32'h1234) begin errors++; $display("FAIL pipe_hold_write_data: got %0h exp 1234", bus.write_data); end
  endtask

  // Pipeline writes reg 20 on 6 consecutive edges; results 9..12 pushed on
  // edges 2..5. Count is nonzero before edges 3..6, so 4 blocked cycles.
  task automatic test_fifo_stall();
    logic [15:0] exp_stall;
`ifdef WB_STALL_COUNT_EN
    exp_stall = 16'd4;
`else
    exp_stall = 16'd0;
`endif
    bus.pipe_wen   = 1'b1;
    bus.pipe_waddr = 5'd20;
    bus.pipe_wdata = 32'hCAFE0020;
    for (int e = 1; e <= 6; e++) begin
      if (e >= 2 && e <= 5) begin
        bus.lu_valid = 1'b1;
        bus.lu_waddr = 5'(9 + e - 2);
        bus.lu_wdata = 32'hA0 + 32'(e - 2);
      end else begin
        bus.lu_valid = 1'b0;
      end
      step();
      checks++; if (bus.write_reg !== 5'd20 || bus.reg_write !== 1'b1) begin errors++; $display("FAIL stall_pipe_edge%0d: got we=%0h reg=%0d exp we=1 reg=20", e, bus.reg_write, bus.write_reg); end
      if (e == 5) begin
        checks++; if (bus.lu_ready !== 1'b0) begin errors++; $display("FAIL full_lu_ready: got %0h exp 0", bus.lu_ready); end
      end
    end
    bus.lu_valid = 1'b0;
    checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL full_fifo_count: got %0d exp 4", bus.fifo_count); end
    checks++; if (bus.stall_cnt !== exp_stall) begin errors++; $display("FAIL stall_cnt: got %0d exp %0d", bus.stall_cnt, exp_stall); end
    bus.pipe_wen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (bus.reg_write !== 1'b1 || bus.write_reg !== 5'(9 + k) || bus.write_data !== 32'hA0 + 32'(k)) begin
        errors++; $display("FAIL drain_%0d: got we=%0h reg=%0d data=%0h exp we=1 reg=%0d data=%0h", k, bus.reg_write, bus.write_reg, bus.write_data, 9 + k, 32'hA0 + 32'(k));
      end
      if (k == 0) begin
        checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL drain_lu_ready: got %0h exp 1", bus.lu_ready); end
      end
    end
    step();
    checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL drained_reg_write: got %0h exp 0", bus.reg_write); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL drained_fifo_count: got %0d exp 0", bus.fifo_count); end
    checks++; if (bus.stall_cnt !== exp_stall) begin errors++; $display("FAIL stall_cnt_hold: got %0d exp %0d", bus.stall_cnt, exp_stall); end
  endtask

  task automatic test_waw_kill();
    logic [15:0] exp_stall;
`ifdef WB_STALL_COUNT_EN
    exp_stall = 16'd5;
`else
    exp_stall = 16'd0;
`endif
    bus.lu_valid = 1'b1;
    bus.lu_waddr = 5'd5;
    bus.lu_wdata = 32'h55;
    step();
    bus.lu_valid   = 1'b0;
    bus.pipe_wen   = 1'b1;
    bus.pipe_waddr = 5'd5;
    bus.pipe_wdata = 32'h77;
    bus.chk_reg    = 5'd5;
    #1;
    checks++; if (bus.chk_pending !== 1'b1) begin errors++; $display("FAIL waw_pending_before: got %0h exp 1", bus.chk_pending); end
    checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL waw_count_before: got %0d exp 1", bus.fifo_count); end
    step();
    bus.pipe_wen = 1'b0;
    checks++; if (bus.reg_write !== 1'b1 || bus.write_reg !== 5'd5 || bus.write_data !== 32'h77) begin
      errors++; $display("FAIL waw_pipe_write: got we=%0h reg=%0d data=%0h exp we=1 reg=5 data=77", bus.reg_write, bus.write_reg, bus.write_data);
    end
    checks++; if (bus.chk_pending !== 1'b0) begin errors++; $display("FAIL waw_pending_after: got %0h exp 0", bus.chk_pending); end
    checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL waw_killed_kept: got %0d exp 1", bus.fifo_count); end
    checks++; if (bus.stall_cnt !== exp_stall) begin errors++; $display("FAIL waw_stall_cnt: got %0d exp %0d", bus.stall_cnt, exp_stall); end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++; if (bus.reg_write !== 1'b0 || bus.write_data !== 32'h77) begin
        errors++; $display("FAIL waw_no_stale_%0d: got we=%0h data=%0h exp we=0 data=77", k, bus.reg_write, bus.write_data);
      end
    end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL waw_popped_count: got %0d exp 0", bus.fifo_count); end
    bus.chk_reg = 5'd0;
  endtask

  task automatic test_zero_addr();
    bus.lu_valid = 1'b1;
    bus.lu_waddr = 5'd0;
    bus.lu_wdata = 32'h99;
    #1;
    checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL zero_lu_ready: got %0h exp 1", bus.lu_ready); end
    step();
    bus.lu_valid = 1'b0;
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL zero_fifo_count: got %0d exp 0", bus.fifo_count); end
    step();
    checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL zero_no_write: got %0h exp 0", bus.reg_write); end
    // Pipeline write to r0 must not block a pop; push and pop share an edge.
    bus.lu_valid = 1'b1;
    bus.lu_waddr = 5'd7;
    bus.lu_wdata = 32'h70;
    step();
    bus.pipe_wen   = 1'b1;
    bus.pipe_waddr = 5'd0;
    bus.pipe_wdata = 32'hFFFF;
    bus.lu_waddr   = 5'd3;
    bus.lu_wdata   = 32'h33;
    step();
    bus.pipe_wen = 1'b0;
    bus.lu_valid = 1'b0;
    checks++; if (bus.reg_write !== 1'b1 || bus.write_reg !== 5'd7 || bus.write_data !== 32'h70) begin
      errors++; $display("FAIL r0_pipe_pop: got we=%0h reg=%0d data=%0h exp we=1 reg=7 data=70", bus.reg_write, bus.write_reg, bus.write_data);
    end
    checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL push_pop_count: got %0d exp 1", bus.fifo_count); end
    step();
    checks++; if (bus.reg_write !== 1'b1 || bus.write_reg !== 5'd3 || bus.write_data !== 32'h33) begin
      errors++; $display("FAIL push_pop_second: got we=%0h reg=%0d data=%0h exp we=1 reg=3 data=33", bus.reg_write, bus.write_reg, bus.write_data);
    end
    step();
    checks++; if (bus.fifo_count !== 3'd0 || bus.reg_write !== 1'b0) begin errors++; $display("FAIL push_pop_empty: got cnt=%0d we=%0h exp cnt=0 we=0", bus.fifo_count, bus.reg_write); end
  endtask

  task automatic test_async_reset();
    bus.pipe_wen   = 1'b1;
    bus.pipe_waddr = 5'd30;
    bus.pipe_wdata = 32'h3030;
    bus.lu_valid   = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      bus.lu_waddr = 5'(k);
      bus.lu_wdata = 32'(k * 11);
      step();
    end
    bus.lu_valid = 1'b0;
    bus.chk_reg  = 5'd2;
    #1;
    checks++; if (bus.fifo_count !== 3'd3 || bus.chk_pending !== 1'b1) begin errors++; $display("FAIL prereset_state: got cnt=%0d pend=%0h exp cnt=3 pend=1", bus.fifo_count, bus.chk_pending); end
    rst = 1'b1;
    #1;
    checks++; if (bus.reg_write !== 1'b0 || bus.write_reg !== 5'd0 || bus.write_data !== 32'h0) begin
      errors++; $display("FAIL async_reset_outputs: got we=%0h reg=%0d data=%0h exp all 0", bus.reg_write, bus.write_reg, bus.write_data);
    end
    checks++; if (bus.fifo_count !== 3'd0 || bus.chk_pending !== 1'b0 || bus.stall_cnt !== 16'd0) begin
      errors++; $display("FAIL async_reset_state: got cnt=%0d pend=%0h stall=%0d exp all 0", bus.fifo_count, bus.chk_pending, bus.stall_cnt);
    end
    #2;
    rst = 1'b0;
    bus.pipe_wen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (bus.reg_write !== 1'b0 || bus.fifo_count !== 3'd0) begin
        errors++; $display("FAIL postreset_quiet_%0d: got we=%0h cnt=%0d exp we=0 cnt=0", k, bus.reg_write, bus.fifo_count);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_pipe_write();
    test_fifo_stall();
    test_waw_kill();
    test_zero_addr();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writeback-side arbiter directly upstream of the register file write port; its registered outputs drive reg_write / write_reg / write_data.
- Merges two producers onto the single write port:
  - the in-order pipeline MEM/WB write, which has fixed priority;
  - a long-latency unit (mult/div) result stream, buffered in a small FIFO with a valid/ready handshake.
- Also exposes a pending-write lookup so the hazard unit can stall readers of registers with queued results.

Parameters:
- DEPTH, 4, number of FIFO entries for long-latency results (power of 2, >= 2)
- ADDR_W, 5, register address width
- DATA_W, 32, register data width

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- pipe_wen  input  1  pipeline writeback request; no handshake, always accepted
- pipe_waddr  input  ADDR_W  pipeline destination register
- pipe_wdata  input  DATA_W  pipeline write data
- lu_valid  input  1  long-latency result valid
- lu_ready  output  1  FIFO can accept a result this cycle
- lu_waddr  input  ADDR_W  long-latency destination register
- lu_wdata  input  DATA_W  long-latency result data
- chk_reg  input  ADDR_W  register number queried by the hazard unit
- chk_pending  output  1  a live FIFO entry targets chk_reg (combinational)
- reg_write  output  1  to register file RegWrite (registered)
- write_reg  output  ADDR_W  to register file write address (registered)
- write_data  output  DATA_W  to register file write data (registered)
- fifo_count  output  $clog2(DEPTH)+1  number of occupied FIFO entries
- stall_cnt  output  16  writeback-blocked cycle counter (see Optional Feature)

Behaviour:
Reset (rst=1, asynchronous):
- Clears head, tail, count and all entry live bits.
- reg_write=0, write_reg=0, write_data=0, stall_cnt=0.
- Reset mid-operation discards all queued results.

Push (long-latency side):
- lu_ready = (count < DEPTH), derived from the current count only; it does not look ahead at a same-cycle pop.
- A transfer occurs when lu_valid && lu_ready; the entry is stored with live=1 at the tail.
- A transfer with lu_waddr==0 is accepted (handshake completes) but not stored; count is unchanged.

Output selection each posedge (priority order):
1. pipe_wen && pipe_waddr!=0 → next-cycle outputs are reg_write=1, write_reg=pipe_waddr, write_data=pipe_wdata. The FIFO is not popped this cycle.
2. Otherwise, count>0 → pop the head entry. If it is live: reg_write=1 with its addr/data. If it was killed: reg_write=0.
3. Otherwise → reg_write=0. write_reg/write_data hold their previous values.

Other rules:
- pipe_wen with pipe_waddr==0 behaves as no pipeline write; the FIFO may pop.
- Latency: pipeline write visible on outputs 1 cycle after it is presented. A FIFO entry is visible at the earliest 1 cycle after the push edge (no bypass).
- WAW kill: when case 1 fires, every live FIFO entry whose addr==pipe_waddr is cleared to live=0 at the same edge, because the pipeline write is the younger one. Killed entries keep their slot until popped.
- Simultaneous push and pop in one cycle: count is unchanged; both pointers advance.
- A push into the same slot being popped cannot occur: with count==DEPTH, lu_ready=0.
- Pointers wrap modulo DEPTH.
- chk_pending = OR over entries of (live && addr==chk_reg && chk_reg!=0). It reflects state before the current edge and does not consider inputs in flight.
- fifo_count = count, including killed entries not yet popped.

Optional Feature:
- Macro WB_STALL_COUNT_EN.
- Defined: stall_cnt increments by 1 on each posedge where count>0 and case 1 fires (pop blocked). It saturates at 16'hFFFF and is cleared by rst.
- Undefined: no counter logic; stall_cnt is tied to 0.

Test Plan:
- Reset then idle → reg_write=0, write_reg=0, write_data=0, lu_ready=1, fifo_count=0, chk_pending=0.
- pipe_wen=1, waddr=8, wdata=32'h1234 for 1 cycle → next cycle reg_write=1, write_reg=8, write_data=32'h1234; following cycle reg_write=0.
- Push 4 results (regs 9..12, data 32'hA0..A3) while pipe_wen=1 (addr 20) for 6 cycles:
  - lu_ready=0 after the 4th push;
  - fifo_count=4;
  - stall_cnt=4 with WB_STALL_COUNT_EN, 0 without;
  - after pipe_wen drops, writes 9,10,11,12 appear on consecutive cycles in that order.
- Push reg 5 data 32'h55, then pipe write reg 5 data 32'h77 on the next cycle → write 5/32'h77 occurs; chk_reg=5 reads pending=1 before that edge and 0 after; the popped entry yields reg_write=0, so reg 5 is never written with 32'h55.
- Push lu_waddr=0 → handshake completes, fifo_count stays 0, no write ever issued.
- With 3 entries queued, assert rst for half a cycle → all outputs 0 immediately; fifo_count=0; no queued write emerges after reset releases.
